// File: rtl/blink_pkg.sv
// rtl/blink_pkg.sv - shared constants and counter sizing for the LED blinker.
package blink_pkg;

  localparam int C_COUNT_1HZ_DEFAULT = 25_000_000;

  // Never narrower than one bit, so a count of 1 still gets a real register.
  function automatic int count_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/blink_tick.sv
// rtl/blink_tick.sv - wrapping cycle counter emitting a terminal-count strobe.
module blink_tick
  import blink_pkg::*;
#(
  parameter int g_COUNT = C_COUNT_1HZ_DEFAULT
) (
  input  logic i_Clk,
  input  logic i_Rst,
  output logic o_Tick
);

  localparam int              C_W    = count_width(g_COUNT);
  localparam logic [C_W-1:0]  C_LAST = C_W'(g_COUNT - 1);

  logic [C_W-1:0] r_count = '0;
  logic           w_tick;

  assign w_tick = (r_count == C_LAST);
  assign o_Tick = w_tick;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_count <= '0;
    end else if (w_tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + C_W'(1);
    end
  end

  a_count_range : assert property (@(posedge i_Clk) r_count <= C_LAST);

  // With a count of 1 the strobe is legitimately high on every cycle.
  if (g_COUNT > 1) begin : g_strobe_chk
    a_strobe_width : assert property (@(posedge i_Clk) w_tick |=> !w_tick);
  end

endmodule

// File: rtl/blink.sv
// rtl/blink.sv - LED blinker toggling its output once every g_COUNT_1HZ clocks.
module blink
  import blink_pkg::*;
#(
  parameter int g_COUNT_1HZ = C_COUNT_1HZ_DEFAULT
) (
  input  logic i_Clk,
  input  logic i_Rst,
  output logic o_LED
);

  if (g_COUNT_1HZ < 1) begin : g_bad_count
    $error("blink: g_COUNT_1HZ must be at least 1");
  end

  logic w_tick;
  logic r_led = 1'b0;

  blink_tick #(
    .g_COUNT(g_COUNT_1HZ)
  ) u_tick (
    .i_Clk (i_Clk),
    .i_Rst (i_Rst),
    .o_Tick(w_tick)
  );

  // Reset wins over a coincident terminal count, so that edge never toggles.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_led <= 1'b0;
    end else if (w_tick) begin
      r_led <= ~r_led;
    end
  end

  assign o_LED = r_led;

endmodule

// File: tb/tb_blink.sv
// tb/tb_blink.sv - randomized self-checking bench for blink at counts of 50 and 1.
module tb_blink;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic led50;
  logic led1;

  int n_pass  = 0;
  int n_total = 0;
  int e50     = 0;
  int e1      = 0;
  int rises;
  int falls;
  logic prev;

  always #5 clk = ~clk;

  blink #(.g_COUNT_1HZ(50)) u_dut50 (
    .i_Clk(clk),
    .i_Rst(rst),
    .o_LED(led50)
  );

  blink #(.g_COUNT_1HZ(1)) u_dut1 (
    .i_Clk(clk),
    .i_Rst(rst),
    .o_LED(led1)
  );

  // LED level after e edges since reset release: lit during odd half-periods.
  function automatic logic exp_led(input int e, input int n);
    return ((e / n) % 2) == 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step(input logic r, input string tag);
    rst = r;
    @(posedge clk);
    if (r) begin
      e50 = 0;
      e1  = 0;
    end else begin
      e50++;
      e1++;
    end
    @(negedge clk);
    check({tag, "_n50"}, 32'(led50), 32'(exp_led(e50, 50)));
    check({tag, "_n1"},  32'(led1),  32'(exp_led(e1, 1)));
  endtask

  initial begin
    check("powerup_n50", 32'(led50), 32'd0);
    check("powerup_n1",  32'(led1),  32'd0);

    for (int i = 0; i < 100; i++) step(1'b0, "free_run");

    for (int i = 0; i < 5; i++) step(1'b1, "rst_hold");
    for (int i = 0; i < 80; i++) step(1'b0, "post_rst");

    step(1'b1, "mid_rst");
    for (int i = 0; i < 60; i++) step(1'b0, "after_mid");

    step(1'b1, "pre_tc");
    for (int i = 0; i < 49; i++) step(1'b0, "to_tc");
    step(1'b1, "tc_rst");
    for (int i = 0; i < 55; i++) step(1'b0, "after_tc");

    step(1'b1, "period_rst");
    rises = 0;
    falls = 0;
    for (int i = 0; i < 1000; i++) begin
      prev = led50;
      step(1'b0, "period");
      if (!prev && led50) rises++;
      if (prev && !led50) falls++;
    end
    check("period_rises", 32'(rises), 32'd10);
    check("period_falls", 32'(falls), 32'd10);

    for (int i = 0; i < 600; i++) step(($urandom_range(0, 63) == 0), "random");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
